// File: rtl/comp_pkg.sv
// Shared types and constants for the serial word comparator.
package comp_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/four_bit_comp.sv
// Combinational 4-bit unsigned magnitude comparator with one-hot G/L/E verdict.
module four_bit_comp
  import comp_pkg::*;
(
  output logic                G,
  output logic                L,
  output logic                E,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b
);

  assign G = (a > b);
  assign L = (a < b);
  assign E = (a == b);

endmodule

// File: rtl/serial_word_comp.sv
// Sequential magnitude compare of two words streamed MSB-nibble-first over valid/ready.
// Define SERIAL_WORD_COMP_SIGNED_EN to treat operands as two's complement.
module serial_word_comp
  import comp_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] a_nib,
  input  logic [NIBBLE_W-1:0] b_nib,
  output logic                busy,
  output logic                done,
  output logic                G,
  output logic                L,
  output logic                E
);

  localparam int unsigned CntW = $clog2(NIBBLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            decided_q, decided_d;
  logic            g_q, g_d, l_q, l_d, e_q, e_d;
  logic            nib_g, nib_l, nib_e;
  logic            accept;

  four_bit_comp u_nib_comp (
    .G (nib_g),
    .L (nib_l),
    .E (nib_e),
    .a (a_nib),
    .b (b_nib)
  );

  assign busy     = (state_q == COMPARE);
  assign in_ready = busy;
  assign done     = (state_q == DONE);
  assign accept   = in_valid & in_ready;
  assign G        = g_q;
  assign L        = l_q;
  assign E        = e_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    g_d       = g_q;
    l_d       = l_q;
    e_d       = e_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = COMPARE;
          cnt_d     = '0;
          decided_d = 1'b0;
          g_d       = 1'b0;
          l_d       = 1'b0;
          e_d       = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        if (accept) begin
          cnt_d = cnt_q + CntW'(1);
`ifdef SERIAL_WORD_COMP_SIGNED_EN
          // Differing sign bits on the top nibble reverse the unsigned verdict.
          if ((cnt_q == '0) && (a_nib[NIBBLE_W-1] != b_nib[NIBBLE_W-1])) begin
            g_d       = ~nib_g & ~nib_e;
            l_d       = ~nib_l & ~nib_e;
            decided_d = 1'b1;
          end else if (!decided_q && !nib_e) begin
            g_d       = nib_g;
            l_d       = nib_l;
            decided_d = 1'b1;
          end
`else
          if (!decided_q && !nib_e) begin
            g_d       = nib_g;
            l_d       = nib_l;
            decided_d = 1'b1;
          end
`endif
          if (cnt_q == LastCnt) begin
            state_d = DONE;
            e_d     = ~decided_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      g_q       <= 1'b0;
      l_q       <= 1'b0;
      e_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      g_q       <= g_d;
      l_q       <= l_d;
      e_q       <= e_d;
    end
  end

endmodule

// File: tb/tb_serial_word_comp.sv
// Directed self-checking bench for serial_word_comp with NIBBLES=4.
module tb_serial_word_comp;

  localparam int unsigned NIB = 4;
  localparam int          MaxCycles = 50;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic       busy;
  logic       done;
  logic       G, L, E;

  int n_checks;
  int n_errors;

  serial_word_comp #(
    .NIBBLES (NIB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_nib    (a_nib),
    .b_nib    (b_nib),
    .busy     (busy),
    .done     (done),
    .G        (G),
    .L        (L),
    .E        (E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one compare; stall idle cycles are inserted after stall_at beats.
  task automatic run_cmp(input string name, input logic [15:0] a, input logic [15:0] b,
                         input int stall_at, input int stall, input bit valid_with_start,
                         input logic [2:0] exp_gle, input int exp_cycles);
    int cyc;
    int beat;
    int stalled;
    bit seen;
    cyc     = 0;
    beat    = 0;
    stalled = 0;
    seen    = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    in_valid = valid_with_start;
    a_nib    = 4'hF;
    b_nib    = 4'h0;
    if (valid_with_start) check_eq({name, " in_ready_idle"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    cyc = 1;
    while (cyc <= MaxCycles) begin
      @(negedge clk);
      if (cyc == 1) check_eq({name, " gle_cleared"}, 32'({G, L, E}), 32'd0);
      if (done) begin
        seen = 1'b1;
        break;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      if (in_ready && beat < int'(NIB)) begin
        if (beat == stall_at && stalled < stall) begin
          stalled++;
        end else begin
          in_valid = 1'b1;
          a_nib    = a[15-4*beat -: 4];
          b_nib    = b[15-4*beat -: 4];
          beat++;
        end
      end
      @(posedge clk);
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check_eq({name, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({name, " latency"}, 32'(cyc), 32'(exp_cycles));
      check_eq({name, " gle"}, 32'({G, L, E}), 32'(exp_gle));
      check_eq({name, " busy_in_done"}, 32'({busy, in_ready}), 32'd0);
      @(negedge clk);
      check_eq({name, " done_pulse"}, 32'(done), 32'd0);
      check_eq({name, " gle_hold"}, 32'({G, L, E}), 32'(exp_gle));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    start    = 1'b0;
    in_valid = 1'b0;
    a_nib    = 4'h0;
    b_nib    = 4'h0;
    rst_n    = 1'b0;
    #12;
    check_eq("reset outs", 32'({busy, done, in_ready, G, L, E}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmp("eq", 16'h1234, 16'h1234, 0, 0, 1'b0, 3'b001, 5);
    run_cmp("gt_last", 16'h1235, 16'h1234, 0, 0, 1'b0, 3'b100, 5);
    run_cmp("lt_first", 16'h0FFF, 16'h1000, 0, 0, 1'b0, 3'b010, 5);
    run_cmp("stall", 16'hABCD, 16'hABCC, 2, 2, 1'b0, 3'b100, 7);
    run_cmp("start_valid", 16'hFFFF, 16'h0000, 0, 0, 1'b1, 3'b100, 5);

    // Abort mid-compare: 0x12.. vs 0x13.. decides L on beat 2, then reset.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    a_nib    = 4'h1;
    b_nib    = 4'h1;
    @(negedge clk);
    a_nib = 4'h2;
    b_nib = 4'h3;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("abort partial_l", 32'({G, L, E}), 32'b010);
    check_eq("abort busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort outs", 32'({busy, done, in_ready, G, L, E}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort no_done", 32'({busy, done}), 32'd0);
    end
    rst_n = 1'b1;

    run_cmp("after_abort", 16'h0000, 16'h0001, 0, 0, 1'b0, 3'b010, 5);
`ifdef SERIAL_WORD_COMP_SIGNED_EN
    run_cmp("sign", 16'h8000, 16'h0001, 0, 0, 1'b0, 3'b010, 5);
`else
    run_cmp("sign", 16'h8000, 16'h0001, 0, 0, 1'b0, 3'b100, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
